// File: rtl/loop_tournament_bht.sv
// Branch history table: bimodal counter, loop-trip predictor and a 2-bit tournament arbiter per entry.
// Invalidation walks one row per cycle, so each row only needs a narrow write port.
module loop_tournament_bht #(
    parameter bit          RVC             = 1'b1,
    parameter int unsigned VLEN            = 64,
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned CTR_BITS        = 2,
    parameter int unsigned LOOP_BITS       = 8,
    parameter int unsigned MODE            = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       bht_update_valid_i,
    input  logic [VLEN-1:0]            bht_update_pc_i,
    input  logic                       bht_update_taken_i,
    output logic [INSTR_PER_FETCH-1:0] bht_prediction_valid_o,
    output logic [INSTR_PER_FETCH-1:0] bht_prediction_taken_o,
    output logic                       flush_busy_o
);

    localparam int unsigned NrRows = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned Ra     = $clog2(INSTR_PER_FETCH);
    localparam int unsigned Offset = RVC ? 1 : 2;
    localparam int unsigned RowW   = (NrRows > 1) ? $clog2(NrRows) : 1;
    localparam int unsigned IdxW   = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
    localparam int unsigned SlotW  = (Ra > 0) ? Ra : 1;

    typedef struct packed {
        logic                 valid;
        logic [CTR_BITS-1:0]  ctr;
        logic [1:0]           arb;
        logic [LOOP_BITS-1:0] run;
        logic [LOOP_BITS-1:0] longest;
        logic                 longest_dir;
        logic                 last_dir;
    } entry_t;

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    function automatic entry_t cleared_entry();
        entry_t e;
        e = '0;
        e.ctr[CTR_BITS-1] = 1'b1;
        e.arb = 2'b01;
        return e;
    endfunction

    // Predict a direction change once the current run matches the longest run seen.
    function automatic logic loop_pred(entry_t e);
        if (e.last_dir == e.longest_dir && e.run == e.longest) return ~e.longest_dir;
        return e.longest_dir;
    endfunction

    function automatic logic final_pred(entry_t e);
        logic bp;
        logic lp;
        bp = e.ctr[CTR_BITS-1];
        lp = loop_pred(e);
        if (MODE == 0) return bp;
        if (MODE == 1) return lp;
        if (bp == lp) return bp;
        return e.arb[1] ? lp : bp;
    endfunction

    entry_t           bht_q [NR_ENTRIES];
    entry_t           rd_entry [INSTR_PER_FETCH];
    state_e           state_q, state_d;
    logic [RowW-1:0]  ptr_q, ptr_d;

    logic [VLEN-1:0]  vpc_shift, upd_row_shift, upd_slot_shift;
    logic [RowW-1:0]  vpc_row, upd_row;
    logic [SlotW-1:0] upd_slot;
    logic [IdxW-1:0]  upd_idx;
    logic             upd_en;
    logic             upd_bp, upd_lp;
    entry_t           upd_cur, upd_next;
    logic             unused_bits;

    assign vpc_shift      = vpc_i >> (Ra + Offset);
    assign upd_row_shift  = bht_update_pc_i >> (Ra + Offset);
    assign upd_slot_shift = bht_update_pc_i >> Offset;
    assign vpc_row        = vpc_shift[RowW-1:0];
    assign upd_row        = upd_row_shift[RowW-1:0];
    assign upd_slot       = (RVC && Ra > 0) ? upd_slot_shift[SlotW-1:0] : '0;
    assign upd_idx        = (IdxW'(upd_row) << Ra) | IdxW'(upd_slot);
    assign unused_bits    = ^{vpc_shift, upd_row_shift, upd_slot_shift};

    assign upd_en = bht_update_valid_i && !debug_mode_i && (state_q == StIdle);

    // All next values derive from the pre-update entry.
    always_comb begin
        upd_cur        = bht_q[upd_idx];
        upd_bp         = upd_cur.ctr[CTR_BITS-1];
        upd_lp         = loop_pred(upd_cur);
        upd_next       = upd_cur;
        upd_next.valid = 1'b1;

        if (bht_update_taken_i) begin
            if (upd_cur.ctr != '1) upd_next.ctr = upd_cur.ctr + CTR_BITS'(1);
        end else if (upd_cur.ctr != '0) begin
            upd_next.ctr = upd_cur.ctr - CTR_BITS'(1);
        end

        if (bht_update_taken_i == upd_cur.last_dir) begin
            if (upd_cur.run != '1) upd_next.run = upd_cur.run + LOOP_BITS'(1);
        end else begin
            if (upd_cur.run >= upd_cur.longest) begin
                upd_next.longest     = upd_cur.run;
                upd_next.longest_dir = upd_cur.last_dir;
            end
            upd_next.run      = LOOP_BITS'(1);
            upd_next.last_dir = bht_update_taken_i;
        end

        if (MODE == 2 && upd_bp != upd_lp) begin
            if (upd_lp == bht_update_taken_i) begin
                if (upd_cur.arb != 2'b11) upd_next.arb = upd_cur.arb + 2'd1;
            end else if (upd_cur.arb != 2'b00) begin
                upd_next.arb = upd_cur.arb - 2'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (flush_i) begin
                    state_d = StFlush;
                    ptr_d   = '0;
                end
            end
            StFlush: begin
                if (flush_i) begin
                    ptr_d = '0;
                end else if (ptr_q == RowW'(NrRows - 1)) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + RowW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) bht_q[i] <= cleared_entry();
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (upd_en) bht_q[upd_idx] <= upd_next;
            if (state_q == StFlush) begin
                for (int s = 0; s < INSTR_PER_FETCH; s++) begin
                    bht_q[(IdxW'(ptr_q) << Ra) | IdxW'(s)] <= cleared_entry();
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < INSTR_PER_FETCH; s++) begin
            rd_entry[s]               = bht_q[(IdxW'(vpc_row) << Ra) | IdxW'(s)];
            bht_prediction_valid_o[s] = rd_entry[s].valid && (state_q == StIdle) && !rst_i;
            bht_prediction_taken_o[s] = final_pred(rd_entry[s]);
        end
    end

    assign flush_busy_o = (state_q == StFlush) && !rst_i;

endmodule
